// File: rtl/padding_stream.sv
// Streaming frame padder: forwards interior elements from the input handshake and
// synthesises border elements internally, one padded element per cycle in raster order.
module padding_stream #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 32,
  parameter int unsigned W          = 32,
  parameter int unsigned PAD_T      = 0,
  parameter int unsigned PAD_B      = 0,
  parameter int unsigned PAD_L      = 0,
  parameter int unsigned PAD_R      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pad_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_first,
  output logic                  out_last
);

  localparam int unsigned HP  = H + PAD_T + PAD_B;
  localparam int unsigned WP  = W + PAD_L + PAD_R;
  localparam int unsigned DCW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned ICW = (HP > 1) ? $clog2(HP) : 1;
  localparam int unsigned JCW = (WP > 1) ? $clog2(WP) : 1;
  // One extra bit so offset-from-pad arithmetic wraps cleanly below the interior band
  localparam int unsigned IEW = ICW + 1;
  localparam int unsigned JEW = JCW + 1;

  if (D == 0 || H == 0 || W == 0) begin : g_bad_dims
    $error("padding_stream: D, H and W must each be at least 1");
  end

  logic [DCW-1:0]        d_cnt, d_nxt;
  logic [ICW-1:0]        i_cnt, i_nxt;
  logic [JCW-1:0]        j_cnt, j_nxt;
  logic [DATA_WIDTH-1:0] pad_latched;

  logic [IEW-1:0]        row_off;
  logic [JEW-1:0]        col_off;
  logic                  row_in, col_in, interior;
  logic                  d_end, i_end, j_end;
  logic                  is_first, is_last;
  logic                  load, advance;
  logic [DATA_WIDTH-1:0] fill_value;

  // Position decode: an unsigned offset below the pad band wraps above H/W
  assign row_off  = {1'b0, i_cnt} - IEW'(PAD_T);
  assign col_off  = {1'b0, j_cnt} - JEW'(PAD_L);
  assign row_in   = row_off < IEW'(H);
  assign col_in   = col_off < JEW'(W);
  assign interior = row_in && col_in;

  assign d_end    = (d_cnt == DCW'(D - 1));
  assign i_end    = (i_cnt == ICW'(HP - 1));
  assign j_end    = (j_cnt == JCW'(WP - 1));
  assign is_first = (d_cnt == '0) && (i_cnt == '0) && (j_cnt == '0);
  assign is_last  = d_end && i_end && j_end;

  // Output register free or draining this cycle
  assign load     = !out_valid || out_ready;
  assign in_ready = rst && interior && load;
  assign advance  = load && (!interior || in_valid);

  // The frame's first element already uses the value being latched for it
  assign fill_value = is_first ? pad_value : pad_latched;

  // Raster-order counter successor
  always_comb begin
    d_nxt = d_cnt;
    i_nxt = i_cnt;
    j_nxt = j_cnt;
    if (j_end) begin
      j_nxt = '0;
      if (i_end) begin
        i_nxt = '0;
        d_nxt = d_end ? '0 : d_cnt + DCW'(1);
      end else begin
        i_nxt = i_cnt + ICW'(1);
      end
    end else begin
      j_nxt = j_cnt + JCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_cnt       <= '0;
      i_cnt       <= '0;
      j_cnt       <= '0;
      pad_latched <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (advance) begin
        d_cnt     <= d_nxt;
        i_cnt     <= i_nxt;
        j_cnt     <= j_nxt;
        out_valid <= 1'b1;
        out_data  <= interior ? in_data : fill_value;
        out_first <= is_first;
        out_last  <= is_last;
        if (is_first) begin
          pad_latched <= pad_value;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_padding_stream.sv
// Scoreboard bench for padding_stream: four instances cover the padding geometries,
// one is selected per case and its outputs are checked against queued expectations.
module tb_padding_stream;

  localparam int unsigned DW = 16;
  localparam int NI = 4;
  localparam int P_D [NI] = '{1, 1, 2, 1};
  localparam int P_H [NI] = '{2, 1, 2, 3};
  localparam int P_W [NI] = '{2, 2, 2, 3};
  localparam int P_T [NI] = '{1, 0, 1, 0};
  localparam int P_B [NI] = '{1, 1, 1, 0};
  localparam int P_L [NI] = '{1, 2, 1, 0};
  localparam int P_R [NI] = '{1, 0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NI-1:0][DW-1:0]  pad_value, in_data, out_data;
  logic [NI-1:0]          in_valid, in_ready, out_valid, out_ready, out_first, out_last;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    padding_stream #(
      .DATA_WIDTH(DW), .D(P_D[g]), .H(P_H[g]), .W(P_W[g]),
      .PAD_T(P_T[g]), .PAD_B(P_B[g]), .PAD_L(P_L[g]), .PAD_R(P_R[g])
    ) u_dut (
      .clk(clk), .rst(rst_n), .pad_value(pad_value[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
      .out_first(out_first[g]), .out_last(out_last[g])
    );
  end

  typedef struct packed {
    logic          first;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] feed_q[$];
  int            tmp[$];
  int            checks = 0;
  int            errors = 0;
  int            sel = 0;
  int            pops = 0;
  int            rdy_cnt = 0;
  bit            abort = 0;
  bit            nb_en = 0;
  bit            nb_armed = 0;
  bit            stall_prev = 0;
  exp_t          held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops and compares on every output handshake of the selected instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || exp_q.size() == 0) begin
      stall_prev = 0;
    end else begin
      if (in_ready[sel]) rdy_cnt++;
      if (nb_en && nb_armed) chk("no_bubble_valid", 32'(out_valid[sel]), 32'd1);
      if (stall_prev && out_valid[sel])
        chk("stall_hold", 32'({out_first[sel], out_last[sel], out_data[sel]}), 32'(held));
      if (out_valid[sel] && out_ready[sel]) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data[sel]), 32'(e.data));
        chk("out_first", 32'(out_first[sel]), 32'(e.first));
        chk("out_last", 32'(out_last[sel]), 32'(e.last));
        pops++;
        nb_armed = 1;
        stall_prev = 0;
      end else if (out_valid[sel]) begin
        chk("stall_in_ready", 32'(in_ready[sel]), 32'd0);
        held = '{first: out_first[sel], last: out_last[sel], data: out_data[sel]};
        stall_prev = 1;
      end else begin
        stall_prev = 0;
      end
    end
  end

  task automatic push_tmp();
    for (int i = 0; i < tmp.size(); i++)
      exp_q.push_back('{first: (i == 0), last: (i == tmp.size() - 1), data: DW'(tmp[i])});
  endtask

  task automatic load_feed(input int first_val, input int n);
    for (int i = 0; i < n; i++) feed_q.push_back(DW'(first_val + i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pops = 0;
    rdy_cnt = 0;
    nb_armed = 0;
  endtask

  // Presents feed_q on instance k; optional idle gap and next-cycle latency check
  task automatic feed(input int k, input int gap, input bit lat);
    bit acc;
    int budget;
    logic [DW-1:0] v;
    while (feed_q.size() > 0 && !abort) begin
      for (int c = 0; c < gap; c++) begin
        in_valid[k] = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid[k] = 1'b1;
      in_data[k]  = feed_q[0];
      acc = 0;
      budget = 0;
      while (!acc && !abort) begin
        @(negedge clk);
        acc = in_ready[k];
        @(posedge clk);
        #1;
        budget++;
        if (!acc && budget > 500) begin
          chk("accept_timeout", 32'd0, 32'd1);
          abort = 1;
        end
      end
      if (acc) begin
        v = feed_q.pop_front();
        in_valid[k] = 1'b0;
        if (lat) begin
          @(negedge clk);
          chk("latency_valid", 32'(out_valid[k]), 32'd1);
          chk("latency_data", 32'(out_data[k]), 32'(v));
        end
      end
    end
    in_valid[k] = 1'b0;
  endtask

  // Drives out_ready (mode 0: always 1, mode 1: pattern 1,0,0) until the scoreboard drains
  task automatic run_ready(input int k, input int mode);
    int cyc = 0;
    int ph = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      out_ready[k] = (mode == 0) ? 1'b1 : (ph == 0);
      ph = (ph + 1) % 3;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready[k] = 1'b0;
    if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_case1();
    tmp = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
    push_tmp();
    load_feed(1, 4);
  endtask

  task automatic push_case4();
    int cnt;
    int pv;
    bit inside_band;
    for (int f = 0; f < 2; f++) begin
      pv  = (f == 0) ? 0 : 7;
      cnt = (f == 0) ? 1 : 11;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            inside_band = (i >= 1 && i < 3 && j >= 1 && j < 3);
            exp_q.push_back('{first: (d == 0 && i == 0 && j == 0),
                              last:  (d == 1 && i == 3 && j == 3),
                              data:  DW'(inside_band ? cnt : pv)});
            if (inside_band) cnt++;
          end
    end
    load_feed(1, 8);
    load_feed(11, 8);
  endtask

  initial begin
    int budget;
    pad_value = '0;
    pad_value[1] = DW'(9);
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '0;
    in_data = '0;
    #12;
    for (int k = 0; k < NI; k++) begin
      chk("reset_out_valid", 32'(out_valid[k]), 32'd0);
      chk("reset_out_data", 32'(out_data[k]), 32'd0);
      chk("reset_out_first", 32'(out_first[k]), 32'd0);
      chk("reset_out_last", 32'(out_last[k]), 32'd0);
      chk("reset_in_ready", 32'(in_ready[k]), 32'd0);
    end

    // Symmetric border, continuous ready
    sel = 0;
    do_reset();
    push_case1();
    fork
      feed(0, 0, 0);
      run_ready(0, 0);
    join
    chk("case1_in_ready_cycles", 32'(rdy_cnt), 32'd4);

    // Same frame under backpressure
    do_reset();
    push_case1();
    fork
      feed(0, 0, 0);
      run_ready(0, 1);
    join

    // Asymmetric padding, pad value 9
    sel = 1;
    do_reset();
    tmp = '{9, 9, 5, 6, 9, 9, 9, 9};
    push_tmp();
    load_feed(5, 2);
    fork
      feed(1, 0, 0);
      run_ready(1, 0);
    join

    // Two channels, back-to-back frames, pad value changes mid-frame
    sel = 2;
    pad_value[2] = '0;
    do_reset();
    push_case4();
    nb_en = 1;
    fork
      feed(2, 0, 0);
      run_ready(2, 0);
      begin
        budget = 0;
        while (pops < 5 && budget < 500) begin
          @(posedge clk);
          budget++;
        end
        #2;
        pad_value[2] = DW'(7);
      end
    join
    nb_en = 0;

    // Pure pass-through with gapped input
    sel = 3;
    do_reset();
    tmp = '{20, 21, 22, 23, 24, 25, 26, 27, 28};
    push_tmp();
    load_feed(20, 9);
    fork
      feed(3, 2, 1);
      run_ready(3, 0);
    join

    // Reset mid-frame, then a full clean frame
    sel = 0;
    do_reset();
    push_case1();
    fork
      feed(0, 0, 0);
      run_ready(0, 0);
      begin
        budget = 0;
        while (pops < 6 && budget < 500) begin
          @(posedge clk);
          budget++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid[0]), 32'd0);
        chk("midreset_in_ready", 32'(in_ready[0]), 32'd0);
        abort = 1;
        exp_q.delete();
      end
    join
    feed_q.delete();
    abort = 0;
    in_valid = '0;
    out_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    pops = 0;
    push_case1();
    fork
      feed(0, 0, 0);
      run_ready(0, 0);
    join
    chk("post_reset_pops", 32'(pops), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/padding_stream.md
# padding_stream

Streaming, handshake-driven successor to the combinational-width frame padder. It accepts an unpadded D×H×W feature map one element per cycle in raster order (channel, row, column). It emits the padded D×(H+PAD_T+PAD_B)×(W+PAD_L+PAD_R) map one element per cycle. Border elements are generated internally and interior elements are forwarded from the input. It sits between the feature-map buffer and the convolution window generator, so whole-frame wide buses are no longer needed.

## Interface
- DATA_WIDTH, 16, element width in bits
- D, 1, channel count
- H, 32, input rows
- W, 32, input columns
- PAD_T, 0, rows of padding above
- PAD_B, 0, rows of padding below
- PAD_L, 0, columns of padding left
- PAD_R, 0, columns of padding right
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- pad_value  input  DATA_WIDTH  border fill value, sampled at frame start
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  DATA_WIDTH  unpadded element, raster order
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  DATA_WIDTH  padded element, raster order
- out_first  output  1  out_data is element (0,0,0) of a frame
- out_last  output  1  out_data is the final element of a frame

## Operation
- Output position counters: d in 0..D-1, i in 0..HP-1, j in 0..WP-1, with HP=H+PAD_T+PAD_B and WP=W+PAD_L+PAD_R. Counters reset to 0.
- Position is interior iff PAD_T ≤ i < PAD_T+H and PAD_L ≤ j < PAD_L+W. Otherwise it is border.
- load = !out_valid || out_ready, meaning the output register is free or draining this cycle.
- Border position with load: output register ← pad_latched, and the counters advance. No input is consumed.
- Interior position: in_ready = load. On in_valid && in_ready, the output register ← in_data and the counters advance.
- in_ready is 0 at every border position, regardless of in_valid.
- Counter advance order: j++; at j=WP-1, j←0 and i++; at i=HP-1, i←0 and d++; at d=D-1, d←0. The next frame starts with no bubble.
- pad_latched ← pad_value when loading position (0,0,0). Changes to pad_value mid-frame do not affect the current frame.
- At (0,0,0), if PAD_T=0 and PAD_L=0, the element is interior and pad_value is still latched there.
- out_first and out_last are registered alongside out_data. out_last is 1 for position (D-1,HP-1,WP-1).
- All PAD_*=0 gives a pure registered pass-through with out_first and out_last framing.
- Counter widths are $clog2 of their ranges, minimum 1 bit.
- Compile-time check: D, H, W ≥ 1.

## Timing
- Reset (rst=0, asynchronous) sets: out_valid=0, out_data=0, out_first=0, out_last=0, counters=0, pad_latched=0. in_ready=0 while rst=0.
- Reset mid-frame discards the partial frame. After release, the first output is position (0,0,0) of a new frame.
- Latency: an input accepted on cycle N appears on out_data from cycle N+1.
- Border elements appear 1 cycle after load.
- Throughput: 1 element/cycle when out_ready=1 and in_valid=1 at interior positions.
- Output handshake: while out_valid=1 && out_ready=0, out_data, out_first and out_last hold stable and in_ready=0.
- Input stall at an interior position (in_valid=0 with load): out_valid drops to 0 the next cycle if the register drained. The counters hold.
- Simultaneous drain and load in one cycle is allowed, so there is no bubble.

## Test plan
- D=1,H=2,W=2, all PAD=1, pad_value=0, inputs 1,2,3,4, out_ready=1 → 16 outputs 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0. out_first on output 0, out_last on output 15. in_ready high only on the 4 interior cycles.
- H=1,W=2,PAD_T=0,PAD_B=1,PAD_L=2,PAD_R=0, pad_value=9, inputs 5,6 → 9,9,5,6, 9,9,9,9.
- Same as the first case with out_ready toggling 1,0,0,1,… → identical sequence; out_data stable across every stall; no input accepted while out_ready=0 with out_valid=1.
- D=2, back-to-back frames, pad_value changed from 0 to 7 at output 5 of frame 1 → frame 1 borders all 0, frame 2 borders all 7; out_first/out_last pulse once per frame; no idle cycle between frames.
- rst asserted after 6 outputs of the first case → out_valid=0 and in_ready=0 immediately. After release, outputs restart at position (0,0,0) and the full 16-element sequence is correct.
- All PAD=0, H=W=3, in_valid gapped → 9 outputs equal to the inputs, 1-cycle latency, out_last on the 9th.
